// File: rtl/qed_pkg.sv
// qed_pkg: shared QED constants and checker state encoding
package qed_pkg;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam int DUP_REG_BIT = 4;
  localparam logic [4:0] DUP_OFFSET = 5'd16;
  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;
endpackage

// File: rtl/qed_consistency_checker_if.sv
// qed_consistency_checker_if: commit stream plus two register-file read ports; master = core side, slave = checker
interface qed_consistency_checker_if #(parameter int XLEN = 64);
  logic commit_valid;
  logic [31:0] commit_instr;
  logic [4:0] rf_raddr_a, rf_raddr_b;
  logic [XLEN-1:0] rf_rdata_a, rf_rdata_b;
  modport master(output commit_valid, commit_instr, rf_rdata_a, rf_rdata_b, input rf_raddr_a, rf_raddr_b);
  modport slave(input commit_valid, commit_instr, rf_rdata_a, rf_rdata_b, output rf_raddr_a, rf_raddr_b);
endinterface

// File: rtl/qed_commit_classify.sv
// qed_commit_classify: instr -> is_orig/is_dup by key register (rs2 for stores, rd otherwise, x0 ignored)
module qed_commit_classify
  import qed_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_orig,
  output logic        is_dup
);
  logic [4:0] key;
  logic unused_fields;
  assign key = (instr[6:0] == OPC_STORE) ? instr[24:20] : instr[11:7];
  assign is_dup = key[DUP_REG_BIT];
  assign is_orig = (key != 5'd0) && !key[DUP_REG_BIT];
  assign unused_fields = ^{instr[31:25], instr[19:12]};
endmodule

// File: rtl/qed_consistency_checker.sv
// qed_consistency_checker: counts original/duplicate commits (bus), walks x(i)/x(i+16) when counts match; check_en starts, qed_ready/check_done/check_pass/mismatch_idx/cnt_overflow report
module qed_consistency_checker
  import qed_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int CNT_W = 16,
  parameter int NUM_PAIRS = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  qed_consistency_checker_if.slave          bus,
  input  logic                              check_en,
  output logic                              qed_ready,
  output logic                              check_done,
  output logic                              check_pass,
  output logic [4:0]                        mismatch_idx,
  output logic                              cnt_overflow
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [4:0] LAST = 5'(NUM_PAIRS);
  logic [CNT_W-1:0] orig_cnt, dup_cnt;
  logic is_orig, is_dup, neq, pass_n;
  logic [4:0] idx, idx_n, midx_n;
  state_t state, state_n;
  qed_commit_classify u_classify (.instr(bus.commit_instr), .is_orig(is_orig), .is_dup(is_dup));
  assign neq = bus.rf_rdata_a[XLEN-1:0] != bus.rf_rdata_b[XLEN-1:0];
  assign qed_ready = (orig_cnt == dup_cnt) && (orig_cnt != '0) && !cnt_overflow;
  assign check_done = state == REPORT;
  assign bus.rf_raddr_a = (state == CHECK) ? idx : 5'd0;
  assign bus.rf_raddr_b = (state == CHECK) ? idx + DUP_OFFSET : 5'd0;
  always_comb begin
    state_n = state;
    idx_n = idx;
    pass_n = check_pass;
    midx_n = mismatch_idx;
    if (state == IDLE) begin
      if (qed_ready && check_en && !bus.commit_valid) begin
        state_n = CHECK;
        idx_n = 5'd1;
      end
    end else if (state == CHECK) begin
      if (bus.commit_valid) state_n = IDLE;
      else if (neq || idx == LAST) begin
        state_n = REPORT;
        pass_n = !neq;
        midx_n = neq ? idx : 5'd0;
      end else idx_n = idx + 5'd1;
    end else state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig_cnt <= '0;
      dup_cnt <= '0;
      cnt_overflow <= 1'b0;
      state <= IDLE;
      idx <= 5'd0;
      check_pass <= 1'b0;
      mismatch_idx <= 5'd0;
    end else begin
      if (bus.commit_valid && is_orig && orig_cnt != CMAX) orig_cnt <= orig_cnt + 1'b1;
      if (bus.commit_valid && is_dup && dup_cnt != CMAX) dup_cnt <= dup_cnt + 1'b1;
      if (bus.commit_valid && ((is_orig && orig_cnt == CMAX) || (is_dup && dup_cnt == CMAX))) cnt_overflow <= 1'b1;
      state <= state_n;
      idx <= idx_n;
      check_pass <= pass_n;
      mismatch_idx <= midx_n;
    end
  end
endmodule

// File: tb/tb_qed_consistency_checker.sv
// tb_qed_consistency_checker: table-driven commit decode plus directed check, abort, reset and saturation sequences
module tb_qed_consistency_checker;
  import qed_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic check_en = 1'b0;
  logic check_en2 = 1'b0;
  logic qed_ready, check_done, check_pass, cnt_overflow;
  logic qed_ready2, check_done2, check_pass2, cnt_overflow2;
  logic [4:0] mismatch_idx, mismatch_idx2;
  logic [63:0] rf [32];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  qed_consistency_checker_if #(.XLEN(64)) bus ();
  qed_consistency_checker_if #(.XLEN(64)) bus2 ();
  assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
  assign bus.rf_rdata_b = rf[bus.rf_raddr_b];
  assign bus2.rf_rdata_a = 64'd0;
  assign bus2.rf_rdata_b = 64'd0;
  qed_consistency_checker #(.XLEN(64), .CNT_W(16), .NUM_PAIRS(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .check_en(check_en), .qed_ready(qed_ready),
    .check_done(check_done), .check_pass(check_pass), .mismatch_idx(mismatch_idx), .cnt_overflow(cnt_overflow)
  );
  qed_consistency_checker #(.XLEN(64), .CNT_W(4), .NUM_PAIRS(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .check_en(check_en2), .qed_ready(qed_ready2),
    .check_done(check_done2), .check_pass(check_pass2), .mismatch_idx(mismatch_idx2), .cnt_overflow(cnt_overflow2)
  );
  typedef struct {
    logic        valid;
    logic [31:0] instr;
    int          orig;
    int          dup;
    logic        ready;
  } vec_t;
  vec_t vecs [9];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic commit(input logic [31:0] ins);
    bus.commit_valid = 1'b1;
    bus.commit_instr = ins;
    @(negedge clk);
    bus.commit_valid = 1'b0;
  endtask
  task automatic commit2(input logic [31:0] ins);
    bus2.commit_valid = 1'b1;
    bus2.commit_instr = ins;
    @(negedge clk);
    bus2.commit_valid = 1'b0;
  endtask
  task automatic run_check(input string nm, input int exp_lat, input logic exp_pass, input logic [4:0] exp_idx);
    int n = 0;
    check_en = 1'b1;
    while (!check_done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({nm, " raddr_a"}, 64'(bus.rf_raddr_a), 64'd1);
        chk({nm, " raddr_b"}, 64'(bus.rf_raddr_b), 64'd17);
      end
    end
    check_en = 1'b0;
    chk({nm, " latency"}, 64'(n), 64'(exp_lat));
    chk({nm, " pass"}, 64'(check_pass), 64'(exp_pass));
    chk({nm, " idx"}, 64'(mismatch_idx), 64'(exp_idx));
    @(negedge clk);
    chk({nm, " done one cycle"}, 64'(check_done), 64'd0);
  endtask
  task automatic wait_addr(input logic [4:0] a);
    int n = 0;
    while (bus.rf_raddr_a != a && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait raddr", 64'(bus.rf_raddr_a), 64'(a));
  endtask
  initial begin
    int seen;
    for (int i = 0; i < 32; i++) rf[i] = 64'(i % 16) * 64'h1111;
    vecs[0] = '{1'b1, 32'h00100293, 1, 0, 1'b0};
    vecs[1] = '{1'b1, 32'h00100A93, 1, 1, 1'b1};
    vecs[2] = '{1'b1, 32'h00312023, 2, 1, 1'b0};
    vecs[3] = '{1'b1, 32'h01312023, 2, 2, 1'b1};
    vecs[4] = '{1'b1, 32'h00000013, 2, 2, 1'b1};
    vecs[5] = '{1'b1, 32'h000122A3, 2, 2, 1'b1};
    vecs[6] = '{1'b1, 32'h002088B3, 2, 3, 1'b0};
    vecs[7] = '{1'b1, 32'h00012083, 3, 3, 1'b1};
    vecs[8] = '{1'b0, 32'h00100293, 3, 3, 1'b1};
    bus.commit_valid = 1'b0;
    bus.commit_instr = 32'd0;
    bus2.commit_valid = 1'b0;
    bus2.commit_instr = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset ready", 64'(qed_ready), 64'd0);
    chk("reset done", 64'(check_done), 64'd0);
    chk("reset pass", 64'(check_pass), 64'd0);
    chk("reset idx", 64'(mismatch_idx), 64'd0);
    chk("reset ovf", 64'(cnt_overflow), 64'd0);
    chk("reset raddr_a", 64'(bus.rf_raddr_a), 64'd0);
    chk("reset raddr_b", 64'(bus.rf_raddr_b), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      bus.commit_valid = vecs[i].valid;
      bus.commit_instr = vecs[i].instr;
      @(negedge clk);
      bus.commit_valid = 1'b0;
      chk($sformatf("vec%0d orig", i), 64'(dut.orig_cnt), 64'(vecs[i].orig));
      chk($sformatf("vec%0d dup", i), 64'(dut.dup_cnt), 64'(vecs[i].dup));
      chk($sformatf("vec%0d ready", i), 64'(qed_ready), 64'(vecs[i].ready));
    end
    rf[7] = 64'h5;
    rf[23] = 64'h6;
    run_check("mismatch", 8, 1'b0, 5'd7);
    rf[7] = 64'h7777;
    rf[23] = 64'h7777;
    run_check("pass", 16, 1'b1, 5'd0);
    chk("counts kept", 64'(dut.orig_cnt), 64'd3);
    check_en = 1'b1;
    wait_addr(5'd4);
    commit(32'h00100293);
    check_en = 1'b0;
    chk("abort raddr", 64'(bus.rf_raddr_a), 64'd0);
    chk("abort ready", 64'(qed_ready), 64'd0);
    chk("abort orig", 64'(dut.orig_cnt), 64'd4);
    chk("abort pass kept", 64'(check_pass), 64'd1);
    chk("abort idx kept", 64'(mismatch_idx), 64'd0);
    seen = 0;
    check_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (check_done) seen++;
      @(negedge clk);
    end
    check_en = 1'b0;
    chk("abort no done", 64'(seen), 64'd0);
    commit(32'h00100A93);
    chk("re-match ready", 64'(qed_ready), 64'd1);
    check_en = 1'b1;
    wait_addr(5'd9);
    rst_n = 1'b0;
    #1;
    chk("rst raddr_a", 64'(bus.rf_raddr_a), 64'd0);
    chk("rst raddr_b", 64'(bus.rf_raddr_b), 64'd0);
    chk("rst ready", 64'(qed_ready), 64'd0);
    chk("rst pass", 64'(check_pass), 64'd0);
    chk("rst orig", 64'(dut.orig_cnt), 64'd0);
    chk("rst dup", 64'(dut.dup_cnt), 64'd0);
    check_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst state idle", 64'(dut.state), 64'(IDLE));
    chk("rst idle raddr", 64'(bus.rf_raddr_a), 64'd0);
    for (int i = 0; i < 15; i++) commit2(32'h00100293);
    for (int i = 0; i < 15; i++) commit2(32'h00100A93);
    chk("sat full ready", 64'(qed_ready2), 64'd1);
    chk("sat full ovf", 64'(cnt_overflow2), 64'd0);
    commit2(32'h00100293);
    chk("sat orig", 64'(dut2.orig_cnt), 64'hF);
    chk("sat ovf", 64'(cnt_overflow2), 64'd1);
    chk("sat ready", 64'(qed_ready2), 64'd0);
    commit2(32'h00100A93);
    chk("sat dup", 64'(dut2.dup_cnt), 64'hF);
    chk("sat ready stays", 64'(qed_ready2), 64'd0);
    chk("sat ovf stays", 64'(cnt_overflow2), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qed_consistency_checker.md
Name: qed_consistency_checker

Overview:
- Consumer of the QED duplicate-instruction stream: watches committed instructions, decodes each as original or duplicate, and counts both.
- The duplicate register mapping is x(i) -> x(i+16) for i = 1..15. Once the two counts match, the block walks register pairs x(i)/x(i+16) over two register-file read ports and reports consistency.
- Sits beside the core's writeback stage and provides the property signal the formal tool asserts on.

Parameters:
- XLEN, 64, register data width
- CNT_W, 16, width of the original/duplicate commit counters
- NUM_PAIRS, 15, number of register pairs compared (i = 1..NUM_PAIRS)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- commit_valid  input  1  one instruction retires this cycle
- commit_instr  input  32  retiring instruction word
- check_en  input  1  allow a consistency check to start when counts match
- rf_raddr_a  output  5  read address, original register x(i)
- rf_raddr_b  output  5  read address, duplicate register x(i+16)
- rf_rdata_a  input  XLEN  combinational read data for rf_raddr_a
- rf_rdata_b  input  XLEN  combinational read data for rf_raddr_b
- qed_ready  output  1  counts equal, nonzero, no overflow
- check_done  output  1  one-cycle pulse when a check completes
- check_pass  output  1  result of the last completed check; held until the next check completes
- mismatch_idx  output  5  first failing i; 0 if the check passed
- cnt_overflow  output  1  sticky: a counter saturated

Behaviour:
- Reset (async, rst_n=0) values:
  - orig_cnt=0, dup_cnt=0, state=IDLE.
  - rf_raddr_a=0, rf_raddr_b=0.
  - check_done=0, check_pass=0, mismatch_idx=0, cnt_overflow=0.
- Commit decode, applied only when commit_valid=1:
  - opcode = commit_instr[6:0].
  - Store (0100011): the key register is rs2 = instr[24:20].
  - Any other opcode: the key register is rd = instr[11:7].
  - Key register == 0: not counted.
  - Key register bit4 = 1: duplicate, dup_cnt++.
  - Key register bit4 = 0: original, orig_cnt++.
- Counters saturate at 2^CNT_W-1. A saturating increment sets cnt_overflow, which stays set until reset.
- qed_ready = (orig_cnt == dup_cnt) && (orig_cnt != 0) && !cnt_overflow. It is registered-count based, so it reflects commits from previous cycles only.
- FSM states are IDLE, CHECK and REPORT.
- IDLE:
  - If qed_ready && check_en && !commit_valid: go to CHECK with i=1.
  - rf_raddr_a/rf_raddr_b = 0 while idle.
- CHECK:
  - Drive rf_raddr_a = i and rf_raddr_b = i+16.
  - Compare rf_rdata_a against rf_rdata_b in the same cycle.
  - On a mismatch, record mismatch_idx=i and a fail flag, then stop early: go to REPORT.
  - If i == NUM_PAIRS with no mismatch: go to REPORT with a pass.
  - Otherwise i++.
  - Full pass latency is NUM_PAIRS cycles in CHECK plus 1 REPORT cycle.
- REPORT:
  - check_done=1 for exactly one cycle; check_pass and mismatch_idx update in this cycle.
  - Next state is IDLE.
  - Counters are not cleared: checks are repeatable at later match points.
- Commit during CHECK:
  - The commit is still counted.
  - The check aborts and returns to IDLE without asserting check_done; check_pass and mismatch_idx keep their previous values.
- Simultaneous events:
  - Commit in the same cycle IDLE would start: the start is suppressed.
  - check_en deasserted mid-CHECK: ignored, the check completes.
- Reset mid-CHECK: immediate return to the reset values above.

Decomposition:
- Shared package (qed_pkg):
  - OPC_STORE constant.
  - DUP_REG_BIT = 4 and DUP_OFFSET = 16 constants, shared with the instruction-duplication logic.
  - State enum {IDLE, CHECK, REPORT}.
- Sub-module qed_commit_classify: combinational decode of commit_instr to {is_orig, is_dup}, reusable by the formal constraint wrapper.

Test Plan:
- Commit addi x5 then addi x21 (same imm), all register pairs equal, check_en=1 -> qed_ready=1 after the 2nd commit; check_done pulses 16 cycles after the start; check_pass=1; mismatch_idx=0.
- Same sequence but rf x7=0x5, x23=0x6 -> check_done pulses after CHECK reaches i=7; check_pass=0; mismatch_idx=7.
- Stores: sw with rs2=x3 (original), then sw with rs2=x19 (duplicate) -> orig_cnt=1, dup_cnt=1, qed_ready=1; an instruction with rd=x0 leaves both counts unchanged.
- Commit arrives at CHECK i=4 -> FSM returns to IDLE, no check_done pulse, counts now unequal, qed_ready=0, previous check_pass retained.
- Force orig_cnt to 0xFFFF and commit an original -> orig_cnt stays at 0xFFFF, cnt_overflow=1, qed_ready=0 permanently.
- Assert rst_n=0 mid-CHECK at i=9 -> all outputs and counters return to 0 asynchronously; FSM is IDLE on release.
